// File: rtl/token_buffer.sv
// ---------------------------------------------------------------------------
// token_buffer
//
// Purpose: a small line-editor style buffer of tokens for an expression
// evaluator. In EDIT mode, key requests insert a token at the cursor, delete
// the token left of the cursor (backspace), or move the cursor. An eval
// request switches to STREAM mode. The stored tokens are then handed
// downstream one at a time with a valid/ready handshake. After the last
// token is accepted, the buffer returns to EDIT.
//
// Request inputs are level-held keys. Each one is edge-detected against a
// registered copy, so holding a key produces exactly one event. At most one
// event is acted on per cycle. The priority order is
// eval > insert > del > ptrLeft > ptrRight.
//
// Configuration macro: TOKEN_BUFFER_CLEAR_ON_EVAL_EN
//   defined   : the final handshake of a stream also empties the buffer
//               (size=0, ptr=0).
//   undefined : contents, size and cursor survive streaming, so the same
//               expression can be edited and evaluated again.
//
// Ports:
//   clock           in   single clock, rising edge
//   reset           in   asynchronous, active-low reset
//   dataIn          in   token code written on an insert event
//   insert          in   insert key (level)
//   del_pulse       in   backspace key (level)
//   ptrLeft_pulse   in   cursor-left key (level)
//   ptrRight_pulse  in   cursor-right key (level)
//   eval_pulse      in   evaluate key (level)
//   out_ready       in   downstream accepts the current token
//   out_data        out  token being streamed (0 in EDIT)
//   out_valid       out  out_data is valid (high throughout STREAM)
//   out_last        out  out_data is the final token of the stream
//   size            out  number of stored tokens
//   ptr             out  cursor position, 0..size
//   full            out  size == depth
//   empty           out  size == 0
//   busy            out  block is in STREAM
// ---------------------------------------------------------------------------
module token_buffer #(
  parameter int width = 8,
  parameter int depth = 16,
  localparam int cw = $clog2(depth + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] dataIn,
  input  logic             insert,
  input  logic             del_pulse,
  input  logic             ptrLeft_pulse,
  input  logic             ptrRight_pulse,
  input  logic             eval_pulse,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic [cw-1:0]    size,
  output logic [cw-1:0]    ptr,
  output logic             full,
  output logic             empty,
  output logic             busy
);

  // Storage address width. A one-entry buffer still needs a one-bit address.
  localparam int aw = (depth > 1) ? $clog2(depth) : 1;

  typedef enum logic {
    EDIT,
    STREAM
  } state_t;

  state_t           state_q, state_d;
  logic [cw-1:0]    size_q, size_d;
  logic [cw-1:0]    ptr_q, ptr_d;
  logic [cw-1:0]    rd_q, rd_d;
  logic [4:0]       req_q;
  logic [4:0]       req_now;
  logic [4:0]       req_ev;
  logic             do_ins;
  logic             do_del;
  logic [aw-1:0]    rd_addr;
  logic [width-1:0] mem [depth];

  // Bit order of the request vector, from highest to lowest priority:
  // [4] eval, [3] insert, [2] del, [1] ptrLeft, [0] ptrRight.
  assign req_now = {eval_pulse, insert, del_pulse, ptrLeft_pulse, ptrRight_pulse};
  assign req_ev  = req_now & ~req_q;

  // The registered request copies update every cycle, whatever the state.
  // This is what keeps a key that is held through a stream from firing later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_q <= '0;
    end else begin
      req_q <= req_now;
    end
  end

  // State, count, cursor and read-index registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EDIT;
      size_q  <= '0;
      ptr_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      ptr_q   <= ptr_d;
      rd_q    <= rd_d;
    end
  end

  // Next-state logic. Only the highest-priority event in a cycle is
  // considered. If that event is illegal (for example, insert while full),
  // it is dropped, and the lower-priority events of that cycle are dropped
  // with it.
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    ptr_d   = ptr_q;
    rd_d    = rd_q;
    do_ins  = 1'b0;
    do_del  = 1'b0;
    case (state_q)
      EDIT: begin
        if (req_ev[4]) begin
          if (size_q != '0) begin
            state_d = STREAM;
            rd_d    = '0;
          end
        end else if (req_ev[3]) begin
          if (size_q != cw'(depth)) begin
            do_ins = 1'b1;
            ptr_d  = ptr_q + cw'(1);
            size_d = size_q + cw'(1);
          end
        end else if (req_ev[2]) begin
          if (ptr_q != '0) begin
            do_del = 1'b1;
            ptr_d  = ptr_q - cw'(1);
            size_d = size_q - cw'(1);
          end
        end else if (req_ev[1]) begin
          if (ptr_q != '0) begin
            ptr_d = ptr_q - cw'(1);
          end
        end else if (req_ev[0]) begin
          if (ptr_q < size_q) begin
            ptr_d = ptr_q + cw'(1);
          end
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (rd_q == size_q - cw'(1)) begin
            state_d = EDIT;
            rd_d    = '0;
`ifdef TOKEN_BUFFER_CLEAR_ON_EVAL_EN
            size_d  = '0;
            ptr_d   = '0;
`endif
          end else begin
            rd_d = rd_q + cw'(1);
          end
        end
      end
      default: begin
        state_d = EDIT;
      end
    endcase
  end

  // Token storage.
  // An insert opens a gap at the cursor by shifting ptr..size-1 up one slot.
  // A delete closes the slot left of the cursor by shifting the upper part
  // down one slot. The vacated top slot is then cleared, so unused entries
  // always read as zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
    end else if (do_ins) begin
      for (int i = 0; i < depth; i++) begin
        if (cw'(i) == ptr_q) begin
          mem[i] <= dataIn;
        end
      end
      for (int i = 1; i < depth; i++) begin
        if ((cw'(i) > ptr_q) && (cw'(i) <= size_q)) begin
          mem[i] <= mem[i-1];
        end
      end
    end else if (do_del) begin
      for (int i = 0; i < depth - 1; i++) begin
        if ((cw'(i) >= ptr_q - cw'(1)) && (cw'(i) < size_q - cw'(1))) begin
          mem[i] <= mem[i+1];
        end
      end
      for (int i = 0; i < depth; i++) begin
        if (cw'(i) == size_q - cw'(1)) begin
          mem[i] <= '0;
        end
      end
    end
  end

  assign rd_addr   = rd_q[aw-1:0];
  assign out_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign out_data  = (state_q == STREAM) ? mem[rd_addr] : '0;
  assign out_last  = (state_q == STREAM) && (rd_q == size_q - cw'(1));
  assign size      = size_q;
  assign ptr       = ptr_q;
  assign full      = (size_q == cw'(depth));
  assign empty     = (size_q == '0);

endmodule

// File: tb/tb_token_buffer.sv
// ---------------------------------------------------------------------------
// tb_token_buffer
//
// Self-checking bench for token_buffer.
//
// The reference model is a token queue with a cursor and a stream index. It
// follows the documented key rules directly: edge detection of each key,
// priority, and insert/backspace/cursor/eval/stream behaviour. After every
// clock, each DUT output is compared against the model.
//
// The bench runs directed scenarios first, then a randomized phase.
// ---------------------------------------------------------------------------
module tb_token_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] dataIn;
  logic             insert;
  logic             del_pulse;
  logic             ptrLeft_pulse;
  logic             ptrRight_pulse;
  logic             eval_pulse;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic [CW-1:0]    size;
  logic [CW-1:0]    ptr;
  logic             full;
  logic             empty;
  logic             busy;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state.
  logic [WIDTH-1:0] mq[$];
  int               mCur;
  bit               mStream;
  int               mIdx;
  bit               mPrev[5];

  token_buffer #(.width(WIDTH), .depth(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .dataIn         (dataIn),
    .insert         (insert),
    .del_pulse      (del_pulse),
    .ptrLeft_pulse  (ptrLeft_pulse),
    .ptrRight_pulse (ptrRight_pulse),
    .eval_pulse     (eval_pulse),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_last       (out_last),
    .size           (size),
    .ptr            (ptr),
    .full           (full),
    .empty          (empty),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic modelReset();
    mq.delete();
    mCur    = 0;
    mStream = 1'b0;
    mIdx    = 0;
    for (int i = 0; i < 5; i++) mPrev[i] = 1'b0;
  endtask

  // One clock of the reference model, given the input levels seen at that edge.
  task automatic modelStep(input bit ins, input bit dl, input bit lft, input bit rgt,
                           input bit ev, input bit rdy, input logic [WIDTH-1:0] d);
    bit eEv, eIns, eDel, eLft, eRgt;
    eEv  = ev  && !mPrev[0];
    eIns = ins && !mPrev[1];
    eDel = dl  && !mPrev[2];
    eLft = lft && !mPrev[3];
    eRgt = rgt && !mPrev[4];
    mPrev[0] = ev;
    mPrev[1] = ins;
    mPrev[2] = dl;
    mPrev[3] = lft;
    mPrev[4] = rgt;
    if (mStream) begin
      if (rdy) begin
        if (mIdx == mq.size() - 1) begin
          mStream = 1'b0;
          mIdx    = 0;
`ifdef TOKEN_BUFFER_CLEAR_ON_EVAL_EN
          mq.delete();
          mCur = 0;
`endif
        end else begin
          mIdx++;
        end
      end
    end else if (eEv) begin
      if (mq.size() > 0) begin
        mStream = 1'b1;
        mIdx    = 0;
      end
    end else if (eIns) begin
      if (mq.size() < DEPTH) begin
        mq.insert(mCur, d);
        mCur++;
      end
    end else if (eDel) begin
      if (mCur > 0) begin
        mq.delete(mCur - 1);
        mCur--;
      end
    end else if (eLft) begin
      if (mCur > 0) mCur--;
    end else if (eRgt) begin
      if (mCur < mq.size()) mCur++;
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [WIDTH-1:0] expData;
    bit               expLast;
    expData = '0;
    expLast = 1'b0;
    if (mStream) begin
      expData = mq[mIdx];
      expLast = (mIdx == mq.size() - 1);
    end
    checkValue({tag, ".size"},      32'(size),      32'(mq.size()));
    checkValue({tag, ".ptr"},       32'(ptr),       32'(mCur));
    checkValue({tag, ".out_valid"}, 32'(out_valid), 32'(mStream));
    checkValue({tag, ".out_data"},  32'(out_data),  32'(expData));
    checkValue({tag, ".out_last"},  32'(out_last),  32'(expLast));
    checkValue({tag, ".full"},      32'(full),      32'(mq.size() == DEPTH));
    checkValue({tag, ".empty"},     32'(empty),     32'(mq.size() == 0));
    checkValue({tag, ".busy"},      32'(busy),      32'(mStream));
  endtask

  // Drive one cycle of input levels, clock once, advance the model, and check.
  task automatic applyStimulus(input string tag, input bit ins, input bit dl,
                               input bit lft, input bit rgt, input bit ev,
                               input bit rdy, input logic [WIDTH-1:0] d);
    insert         = ins;
    del_pulse      = dl;
    ptrLeft_pulse  = lft;
    ptrRight_pulse = rgt;
    eval_pulse     = ev;
    out_ready      = rdy;
    dataIn         = d;
    @(posedge clock);
    modelStep(ins, dl, lft, rgt, ev, rdy, d);
    #1;
    checkOutput(tag);
  endtask

  task automatic pressInsert(input logic [WIDTH-1:0] d);
    applyStimulus("ins", 1, 0, 0, 0, 0, 0, d);
    applyStimulus("ins_rel", 0, 0, 0, 0, 0, 0, d);
  endtask

  task automatic holdReset();
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("reset");
    @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    reset          = 1'b0;
    dataIn         = '0;
    insert         = 1'b0;
    del_pulse      = 1'b0;
    ptrLeft_pulse  = 1'b0;
    ptrRight_pulse = 1'b0;
    eval_pulse     = 1'b0;
    out_ready      = 1'b0;
    modelReset();
    #3;
    checkOutput("por");
    checkValue("por.empty_const", 32'(empty), 32'd1);
    @(posedge clock);
    #2;
    reset = 1'b1;

    // Three inserts, then an eval with the downstream always ready.
    pressInsert(8'h03);
    pressInsert(8'hA0);
    pressInsert(8'h05);
    checkValue("ex1.size", 32'(size), 32'd3);
    checkValue("ex1.ptr",  32'(ptr),  32'd3);
    applyStimulus("ex1.eval", 0, 0, 0, 0, 1, 1, 8'h00);
    checkValue("ex1.t0", 32'(out_data), 32'h03);
    checkValue("ex1.l0", 32'(out_last), 32'd0);
    applyStimulus("ex1.s1", 0, 0, 0, 0, 0, 1, 8'h00);
    checkValue("ex1.t1", 32'(out_data), 32'hA0);
    applyStimulus("ex1.s2", 0, 0, 0, 0, 0, 1, 8'h00);
    checkValue("ex1.t2", 32'(out_data), 32'h05);
    checkValue("ex1.l2", 32'(out_last), 32'd1);
    applyStimulus("ex1.done", 0, 0, 0, 0, 0, 1, 8'h00);
    checkValue("ex1.busy", 32'(busy), 32'd0);

    // A held insert key produces exactly one event.
    holdReset();
    for (int i = 0; i < 10; i++) applyStimulus("hold", 1, 0, 0, 0, 0, 0, 8'h07);
    applyStimulus("hold_rel", 0, 0, 0, 0, 0, 0, 8'h07);
    checkValue("hold.size", 32'(size), 32'd1);

    // Cursor editing in the middle of the buffer, plus cursor limits.
    holdReset();
    pressInsert(8'h03);
    pressInsert(8'hA0);
    pressInsert(8'h05);
    applyStimulus("left", 0, 0, 1, 0, 0, 0, 8'h00);
    applyStimulus("left_rel", 0, 0, 0, 0, 0, 0, 8'h00);
    pressInsert(8'h07);
    checkValue("edit.ptr3", 32'(ptr), 32'd3);
    applyStimulus("del", 0, 1, 0, 0, 0, 0, 8'h00);
    applyStimulus("del_rel", 0, 0, 0, 0, 0, 0, 8'h00);
    checkValue("edit.ptr2", 32'(ptr), 32'd2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("right", 0, 0, 0, 1, 0, 0, 8'h00);
      applyStimulus("right_rel", 0, 0, 0, 0, 0, 0, 8'h00);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus("lft", 0, 0, 1, 0, 0, 0, 8'h00);
      applyStimulus("lft_rel", 0, 0, 0, 0, 0, 0, 8'h00);
    end
    applyStimulus("del0", 0, 1, 0, 0, 0, 0, 8'h00);
    applyStimulus("del0_rel", 0, 0, 0, 0, 0, 0, 8'h00);
    applyStimulus("edit.eval", 0, 0, 0, 0, 1, 1, 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus("edit.stream", 0, 0, 0, 0, 0, 1, 8'h00);

    // Fill to capacity, then press insert and del on the same edge.
    holdReset();
    for (int i = 0; i < 17; i++) pressInsert(8'(8'h40 + i));
    checkValue("full.flag", 32'(full), 32'd1);
    checkValue("full.size", 32'(size), 32'd16);
    applyStimulus("full.insdel", 1, 1, 0, 0, 0, 0, 8'hEE);
    checkValue("full.size2", 32'(size), 32'd16);
    checkValue("full.ptr2",  32'(ptr),  32'd16);
    applyStimulus("full.rel", 0, 0, 0, 0, 0, 0, 8'h00);
    applyStimulus("full.eval", 0, 0, 0, 0, 1, 1, 8'h00);
    for (int i = 0; i < 17; i++) applyStimulus("full.stream", 0, 0, 0, 0, 0, 1, 8'h00);

    // Stalling handshake, an insert during the stream, then reset mid-stream.
    holdReset();
    for (int i = 0; i < 4; i++) pressInsert(8'(8'h10 + i));
    applyStimulus("stall.eval", 0, 0, 0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 10; i++)
      applyStimulus("stall", (i == 3), 0, 0, 0, 0, (i % 2 == 0), 8'h99);
    checkValue("stall.size", 32'(size), 32'd4);
    applyStimulus("stall.eval2", 0, 0, 0, 0, 1, 1, 8'h00);
    applyStimulus("stall.s1", 0, 0, 0, 0, 0, 1, 8'h00);
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkValue("abort.valid", 32'(out_valid), 32'd0);
    checkValue("abort.size",  32'(size),      32'd0);
    checkOutput("abort");
    @(posedge clock);
    #2;
    // A key held high across reset release fires once on the first edge.
    insert = 1'b1;
    dataIn = 8'h29;
    #1;
    reset = 1'b1;
    applyStimulus("relhold", 1, 0, 0, 0, 0, 0, 8'h29);
    checkValue("relhold.size", 32'(size), 32'd1);
    applyStimulus("relhold2", 1, 0, 0, 0, 0, 0, 8'h29);

    // Randomized key presses and downstream readiness.
    for (int i = 0; i < 600; i++) begin
      d = 8'($urandom);
      applyStimulus("rand",
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 0), d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
